pong_game_ctrl: RTL and testbench

- Top-level Pong game sequencer; the other end of the ball engine's state/serve/ballStatus interface.
- Drives `state` (START/SERVE/PLAY/DONE) and `serve` into the ball engine.
- Consumes the ball engine's `ballStatus` to award points and keep both scores.
- Declares the match winner and emits one-cycle point strobes for the score display and sound logic.

---
 rtl/pong_game_ctrl_if.sv | 37 +++
 rtl/pong_game_ctrl.sv | 142 ++++++++++++++
 tb/tb_pong_game_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_if.sv
// Pong sequencer <-> ball engine / front panel bundle.
// master = game controller, slave = ball engine and display side.
interface pong_game_ctrl_if;
    logic       start_btn;
    logic [1:0] ballStatus;
    logic [1:0] state;
    logic       serve;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;
    logic       point1;
    logic       point2;

    modport master (
        input  start_btn,
        input  ballStatus,
        output state,
        output serve,
        output score1,
        output score2,
        output winner,
        output point1,
        output point2
    );

    modport slave (
        output start_btn,
        output ballStatus,
        input  state,
        input  serve,
        input  score1,
        input  score2,
        input  winner,
        input  point1,
        input  point2
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: START/SERVE/PLAY/DONE, scoring and winner.
// All outputs are registered; synchronous active-low reset.
module pong_game_ctrl #(
    parameter logic [3:0]         WIN_SCORE   = 4'd5,
    parameter int                 DELAY_W     = 24,
    parameter logic [DELAY_W-1:0] SERVE_DELAY = DELAY_W'(12_500_000)
) (
    input  logic              clk,
    input  logic              rst,
    pong_game_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic [1:0] BS_P1 = 2'b01;
    localparam logic [1:0] BS_P2 = 2'b10;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [DELAY_W-1:0] CNT_LAST =
        SERVE_DELAY - DELAY_W'(1);

    state_e             state_q,  state_d;
    logic               serve_q,  serve_d;
    logic [3:0]         score1_q, score1_d;
    logic [3:0]         score2_q, score2_d;
    logic [1:0]         winner_q, winner_d;
    logic               point1_q, point1_d;
    logic               point2_q, point2_d;
    logic [DELAY_W-1:0] cnt_q,    cnt_d;

    logic [3:0] score1_inc;
    logic [3:0] score2_inc;

    assign score1_inc = score1_q + 4'd1;
    assign score2_inc = score2_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_START;
            serve_q  <= 1'b0;
            score1_q <= 4'd0;
            score2_q <= 4'd0;
            winner_q <= WIN_NONE;
            point1_q <= 1'b0;
            point2_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            serve_q  <= serve_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
            point1_q <= point1_d;
            point2_q <= point2_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        serve_d  = serve_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        point1_d = 1'b0;
        point2_d = 1'b0;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_START: begin
                serve_d  = 1'b0;
                score1_d = 4'd0;
                score2_d = 4'd0;
                winner_d = WIN_NONE;
                cnt_d    = '0;
                if (bus.start_btn) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q + DELAY_W'(1);
                end
            end
            ST_PLAY: begin
                // Status 11 is treated as still playing.
                if (bus.ballStatus == BS_P1) begin
                    score1_d = score1_inc;
                    point1_d = 1'b1;
                    if (score1_inc == WIN_SCORE) begin
                        state_d  = ST_DONE;
                        winner_d = WIN_P1;
                    end else begin
                        state_d = ST_SERVE;
                        serve_d = 1'b1;
                    end
                end else if (bus.ballStatus == BS_P2) begin
                    score2_d = score2_inc;
                    point2_d = 1'b1;
                    if (score2_inc == WIN_SCORE) begin
                        state_d  = ST_DONE;
                        winner_d = WIN_P2;
                    end else begin
                        state_d = ST_SERVE;
                        serve_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (bus.start_btn) begin
                    state_d  = ST_START;
                    serve_d  = 1'b0;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    winner_d = WIN_NONE;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    assign bus.state  = state_q;
    assign bus.serve  = serve_q;
    assign bus.score1 = score1_q;
    assign bus.score2 = score2_q;
    assign bus.winner = winner_q;
    assign bus.point1 = point1_q;
    assign bus.point2 = point2_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed vector bench for pong_game_ctrl.
// Runs with WIN_SCORE=3, SERVE_DELAY=4.
module tb_pong_game_ctrl;

    logic clk;
    logic rst;

    pong_game_ctrl_if bus();

    pong_game_ctrl #(
        .WIN_SCORE  (4'd3),
        .DELAY_W    (8),
        .SERVE_DELAY(8'd4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       st;
        logic [1:0] bs;
        logic [1:0] e_state;
        logic       e_serve;
        logic [3:0] e_s1;
        logic [3:0] e_s2;
        logic [1:0] e_win;
        logic       e_p1;
        logic       e_p2;
    } vec_t;

    vec_t vq[$];
    int checks;
    int errors;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [1:0] b);
        rst           = r;
        bus.start_btn = s;
        bus.ballStatus = b;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic s, input logic [1:0] b,
                       input logic [1:0] es, input logic sv,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic [1:0] w, input logic p1,
                       input logic p2);
        vec_t v;
        v.rst = r; v.st = s; v.bs = b;
        v.e_state = es; v.e_serve = sv;
        v.e_s1 = s1; v.e_s2 = s2; v.e_win = w;
        v.e_p1 = p1; v.e_p2 = p2;
        vq.push_back(v);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.start_btn = 1'b0;
        bus.ballStatus = 2'b00;

        // reset and launch
        add(0,0,0, 0,0,0,0,0,0,0);
        add(0,0,0, 0,0,0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0,0,0);
        add(1,1,0, 1,0,0,0,0,0,0);
        add(1,0,0, 1,0,0,0,0,0,0);
        add(1,0,0, 1,0,0,0,0,0,0);
        add(1,0,0, 1,0,0,0,0,0,0);
        add(1,0,0, 2,0,0,0,0,0,0);
        add(1,0,0, 2,0,0,0,0,0,0);
        // player 1 point, status held 3 cycles
        add(1,0,1, 1,1,1,0,0,1,0);
        add(1,0,1, 1,1,1,0,0,0,0);
        add(1,0,1, 1,1,1,0,0,0,0);
        add(1,0,0, 1,1,1,0,0,0,0);
        add(1,0,0, 2,1,1,0,0,0,0);
        // player 2 points up to the win
        add(1,0,2, 1,0,1,1,0,0,1);
        add(1,0,0, 1,0,1,1,0,0,0);
        add(1,0,0, 1,0,1,1,0,0,0);
        add(1,0,0, 1,0,1,1,0,0,0);
        add(1,0,0, 2,0,1,1,0,0,0);
        add(1,0,2, 1,0,1,2,0,0,1);
        add(1,0,0, 1,0,1,2,0,0,0);
        add(1,0,0, 1,0,1,2,0,0,0);
        add(1,0,0, 1,0,1,2,0,0,0);
        add(1,0,0, 2,0,1,2,0,0,0);
        add(1,1,2, 3,0,1,3,2,0,1);
        add(1,0,2, 3,0,1,3,2,0,0);
        add(1,0,1, 3,0,1,3,2,0,0);
        // restart
        add(1,1,0, 0,0,0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0,0,0);
        add(1,1,0, 1,0,0,0,0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].rst, vq[i].st, vq[i].bs);
            chk($sformatf("v%0d.state", i), bus.state, vq[i].e_state);
            chk($sformatf("v%0d.serve", i), bus.serve, vq[i].e_serve);
            chk($sformatf("v%0d.score1", i), bus.score1, vq[i].e_s1);
            chk($sformatf("v%0d.score2", i), bus.score2, vq[i].e_s2);
            chk($sformatf("v%0d.winner", i), bus.winner, vq[i].e_win);
            chk($sformatf("v%0d.point1", i), bus.point1, vq[i].e_p1);
            chk($sformatf("v%0d.point2", i), bus.point2, vq[i].e_p2);
        end

        // reach PLAY, then build score1=2 and reset mid-SERVE at count 2
        for (int i = 0; i < 4; i++) cyc(1, 0, 2'b00);
        chk("seq.play1", bus.state, 2);
        cyc(1, 0, 2'b01);
        for (int i = 0; i < 4; i++) cyc(1, 0, 2'b00);
        chk("seq.play2", bus.state, 2);
        cyc(1, 0, 2'b01);
        chk("seq.s1_two", bus.score1, 2);
        chk("seq.serve_dir", bus.serve, 1);
        cyc(1, 0, 2'b00);
        cyc(1, 0, 2'b00);
        chk("seq.pre_rst", bus.state, 1);
        cyc(0, 1, 2'b01);
        chk("rst.state", bus.state, 0);
        chk("rst.score1", bus.score1, 0);
        chk("rst.score2", bus.score2, 0);
        chk("rst.winner", bus.winner, 0);
        chk("rst.serve", bus.serve, 0);
        chk("rst.point1", bus.point1, 0);

        // start_btn held through SERVE must not change the delay
        cyc(1, 1, 2'b00);
        chk("rl.serve_entry", bus.state, 1);
        n = 0;
        while (bus.state != 2'b10 && n < 20) begin
            cyc(1, 1, 2'b00);
            n++;
        end
        chk("rl.serve_cycles", n, 4);

        // player 1 wins the match
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 2'b01);
            chk($sformatf("p1w%0d.score1", k), bus.score1, k + 1);
            chk($sformatf("p1w%0d.point1", k), bus.point1, 1);
            if (k < 2) begin
                chk($sformatf("p1w%0d.state", k), bus.state, 1);
                for (int j = 0; j < 4; j++) cyc(1, 0, 2'b00);
            end else begin
                chk("p1w.state", bus.state, 3);
                chk("p1w.winner", bus.winner, 1);
            end
        end
        cyc(1, 0, 2'b01);
        chk("p1w.hold_score", bus.score1, 3);
        chk("p1w.hold_point", bus.point1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
